// File: rtl/wakeup_arbiter_pkg.sv
// Shared constants and the wakeup broadcast record used by the wakeup arbiter
// and its round-robin selector.
package wakeup_pkg;

    localparam int TAG_W            = 6;
    localparam int DATA_W           = 32;
    localparam int NUM_WAKEUP_PORTS = 4;
    localparam int PORT_IDX_W       = 2;

    localparam logic [TAG_W-1:0] ZERO_TAG = '0;

    typedef struct packed {
        logic              active;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } wakeup_t;

endpackage

// File: rtl/wakeup_arbiter_if.sv
// Producer request bundle plus the four Rename wakeup broadcast ports.
interface wakeup_arbiter_if #(
    parameter int NUM_REQ = 6
);
    import wakeup_pkg::*;

    // Handshake: producer i raises req_valid[i] and holds tag/value stable until
    // req_ready[i]; a transfer happens in any cycle where both are high. The
    // wakeup ports have no backpressure and broadcast every granted result.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      wakeup_0_active;
    logic [TAG_W-1:0]          wakeup_0_tag;
    logic [DATA_W-1:0]         wakeup_0_value;
    logic                      wakeup_1_active;
    logic [TAG_W-1:0]          wakeup_1_tag;
    logic [DATA_W-1:0]         wakeup_1_value;
    logic                      wakeup_2_active;
    logic [TAG_W-1:0]          wakeup_2_tag;
    logic [DATA_W-1:0]         wakeup_2_value;
    logic                      wakeup_3_active;
    logic [TAG_W-1:0]          wakeup_3_tag;
    logic [DATA_W-1:0]         wakeup_3_value;

    modport master (
        output req_valid, req_tag, req_value,
        input  req_ready,
        input  wakeup_0_active, wakeup_0_tag, wakeup_0_value,
        input  wakeup_1_active, wakeup_1_tag, wakeup_1_value,
        input  wakeup_2_active, wakeup_2_tag, wakeup_2_value,
        input  wakeup_3_active, wakeup_3_tag, wakeup_3_value
    );

    modport slave (
        input  req_valid, req_tag, req_value,
        output req_ready,
        output wakeup_0_active, wakeup_0_tag, wakeup_0_value,
        output wakeup_1_active, wakeup_1_tag, wakeup_1_value,
        output wakeup_2_active, wakeup_2_tag, wakeup_2_value,
        output wakeup_3_active, wakeup_3_tag, wakeup_3_value
    );

endinterface

// File: rtl/wakeup_arbiter_rr_pick.sv
// Rotated first-K-set-bits selector: starting at i_rr_ptr, grants up to
// NUM_WAKEUP_PORTS requests and reports which port each grant lands on.
module wakeup_rr_pick
    import wakeup_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                        i_req,
    input  logic [PTR_W-1:0]                          i_rr_ptr,
    output logic [NUM_REQ-1:0]                        o_grant,
    output logic [NUM_WAKEUP_PORTS-1:0][NUM_REQ-1:0]  o_sel,
    output logic [PTR_W-1:0]                          o_last,
    output logic                                      o_any
);

    int                    idx;
    int                    cnt;
    logic [PTR_W-1:0]      sidx;
    logic [PORT_IDX_W-1:0] pidx;

    // The n-th grant in scan order lands on port n, so ports fill from 0 upward.
    always_comb begin
        o_grant = '0;
        o_sel   = '0;
        o_last  = '0;
        o_any   = 1'b0;
        idx     = 0;
        cnt     = 0;
        sidx    = '0;
        pidx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(i_rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sidx = PTR_W'(idx);
            pidx = PORT_IDX_W'(cnt);
            if (i_req[sidx] && (cnt < NUM_WAKEUP_PORTS)) begin
                o_grant[sidx]     = 1'b1;
                o_sel[pidx][sidx] = 1'b1;
                o_last            = sidx;
                o_any             = 1'b1;
                cnt               = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/wakeup_arbiter.sv
// Shares the four Rename wakeup ports among NUM_REQ producers in round-robin order.
// Define WAKEUP_ARB_REGOUT_EN to register the wakeup outputs (one-cycle latency).
module wakeup_arbiter
    import wakeup_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    wakeup_arbiter_if.slave  wk,
    output logic [PTR_W-1:0] o_rr_ptr
);

    logic [TAG_W-1:0]                       w_tag [NUM_REQ];
    logic [DATA_W-1:0]                      w_val [NUM_REQ];
    logic [NUM_REQ-1:0]                     w_nz_req;
    logic [NUM_REQ-1:0]                     w_x0_req;
    logic [NUM_REQ-1:0]                     w_grant;
    logic [NUM_WAKEUP_PORTS-1:0][NUM_REQ-1:0] w_sel;
    logic [PTR_W-1:0]                       w_last;
    logic                                   w_any;
    logic [PTR_W-1:0]                       r_rr_ptr;
    logic [PTR_W-1:0]                       w_rr_ptr_nxt;
    wakeup_t                                w_port [NUM_WAKEUP_PORTS];
    wakeup_t                                w_out  [NUM_WAKEUP_PORTS];

    // x0 results carry no physical register, so they bypass the port budget.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_tag[gi]    = wk.req_tag[gi*TAG_W +: TAG_W];
        assign w_val[gi]    = wk.req_value[gi*DATA_W +: DATA_W];
        assign w_x0_req[gi] = wk.req_valid[gi] && (w_tag[gi] == ZERO_TAG);
        assign w_nz_req[gi] = wk.req_valid[gi] && (w_tag[gi] != ZERO_TAG);
    end

    wakeup_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (w_nz_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_sel    (w_sel),
        .o_last   (w_last),
        .o_any    (w_any)
    );

    assign wk.req_ready = reset ? (w_grant | w_x0_req) : '0;

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_any) begin
            w_rr_ptr_nxt = (w_last == PTR_W'(NUM_REQ - 1)) ? '0 : w_last + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign o_rr_ptr = r_rr_ptr;

    always_comb begin
        for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
            w_port[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_sel[k][i]) begin
                    w_port[k] = '{active: 1'b1, tag: w_tag[i], value: w_val[i]};
                end
            end
        end
    end

`ifdef WAKEUP_ARB_REGOUT_EN
    wakeup_t r_port [NUM_WAKEUP_PORTS];

    // The register always drains, so req_ready never waits on it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
                r_port[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
                r_port[k] <= w_port[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
            w_out[k] = r_port[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
            w_out[k] = reset ? w_port[k] : '0;
        end
    end
`endif

    assign wk.wakeup_0_active = w_out[0].active;
    assign wk.wakeup_0_tag    = w_out[0].tag;
    assign wk.wakeup_0_value  = w_out[0].value;
    assign wk.wakeup_1_active = w_out[1].active;
    assign wk.wakeup_1_tag    = w_out[1].tag;
    assign wk.wakeup_1_value  = w_out[1].value;
    assign wk.wakeup_2_active = w_out[2].active;
    assign wk.wakeup_2_tag    = w_out[2].tag;
    assign wk.wakeup_2_value  = w_out[2].value;
    assign wk.wakeup_3_active = w_out[3].active;
    assign wk.wakeup_3_tag    = w_out[3].tag;
    assign wk.wakeup_3_value  = w_out[3].value;

endmodule

// File: tb/tb_wakeup_arbiter.sv
// Bench for wakeup_arbiter: directed scenarios pinned with literal values, then
// randomized producers checked every cycle against a queue-based reference model.
module tb_wakeup_arbiter;
    import wakeup_pkg::*;

    localparam int N  = 6;
    localparam int PB = 1 + TAG_W + DATA_W;
    localparam int PW = NUM_WAKEUP_PORTS * PB;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wakeup_arbiter_if #(.NUM_REQ(N)) bus ();
    logic [2:0] rr_ptr_dbg;

    wakeup_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .wk       (bus),
        .o_rr_ptr (rr_ptr_dbg)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    bit fair_en = 1'b0;

    bit                v [N];
    logic [TAG_W-1:0]  t [N];
    logic [DATA_W-1:0] d [N];
    int                wait_cyc [N];

    int            m_ptr = 0;
    int            m_list[$];
    logic [N-1:0]  m_ready;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] dut_ports();
        return {bus.wakeup_3_active, bus.wakeup_3_tag, bus.wakeup_3_value,
                bus.wakeup_2_active, bus.wakeup_2_tag, bus.wakeup_2_value,
                bus.wakeup_1_active, bus.wakeup_1_tag, bus.wakeup_1_value,
                bus.wakeup_0_active, bus.wakeup_0_tag, bus.wakeup_0_value};
    endfunction

    function automatic logic [PW-1:0] mk_lit(input int k, input logic [TAG_W-1:0] tg,
                                             input logic [DATA_W-1:0] vl);
        logic [PW-1:0] e;
        e = '0;
        e[k*PB +: PB] = {1'b1, tg, vl};
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]                  = v[i];
            bus.req_tag[i*TAG_W +: TAG_W]     = t[i];
            bus.req_value[i*DATA_W +: DATA_W] = d[i];
        end
    endtask

    // ---------------- reference model ----------------
    // Walk producers in rotated order; x0 always granted, others take the next free port.
    task automatic model_eval();
        int i;
        m_list.delete();
        m_ready = '0;
        if (reset) begin
            for (int off = 0; off < N; off++) begin
                i = (m_ptr + off) % N;
                if (v[i]) begin
                    if (t[i] == 0) begin
                        m_ready[i] = 1'b1;
                    end else if (m_list.size() < NUM_WAKEUP_PORTS) begin
                        m_list.push_back(i);
                        m_ready[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [PW-1:0] model_ports();
        logic [PW-1:0] e;
        e = '0;
        for (int k = 0; k < m_list.size(); k++) begin
            e = e | mk_lit(k, t[m_list[k]], d[m_list[k]]);
        end
        return e;
    endfunction

    // ---------------- scoreboard (one compare point per cycle) ----------------
    task automatic sample();
        logic [PW-1:0] e;
        @(negedge clk);
        model_eval();
        chk("ready", bus.req_ready, m_ready);
        chk("rr_ptr", rr_ptr_dbg, m_ptr);
`ifndef WAKEUP_ARB_REGOUT_EN
        exp_q.push_back(model_ports());
`endif
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("ports", dut_ports(), e);
        end
        if (fair_en) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && m_ready[i]) chk("fairness", (wait_cyc[i] <= 1), 1);
            end
        end
    endtask

    task automatic advance();
        model_eval();
`ifdef WAKEUP_ARB_REGOUT_EN
        exp_q.push_back(model_ports());
`endif
        if (reset && (m_list.size() > 0)) m_ptr = (m_list[$] + 1) % N;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && m_ready[i]) begin
                v[i] = 1'b0;
            end else if (v[i]) begin
                wait_cyc[i]++;
            end
        end
        drive();
    endtask

    task automatic lits_pre(input string name, input logic [PW-1:0] e);
`ifndef WAKEUP_ARB_REGOUT_EN
        chk(name, dut_ports(), e);
`endif
    endtask

    task automatic lits_post(input string name, input logic [PW-1:0] e);
`ifdef WAKEUP_ARB_REGOUT_EN
        chk(name, dut_ports(), e);
`endif
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; t[i] = '0; d[i] = '0; wait_cyc[i] = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] e;
        logic [2:0]    r;
`ifdef WAKEUP_ARB_REGOUT_EN
        exp_q.push_back('0);
`endif
        clear_all();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; t[i] = TAG_W'(i + 1); d[i] = $urandom;
        end
        drive();
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ports", dut_ports(), 0);
        chk("rst_ptr", rr_ptr_dbg, 0);
        sample();
        advance();
        sample();
        #2;
        reset = 1'b1;
        clear_all();
        drive();
        advance();
        sample();
        chk("idle_ptr", rr_ptr_dbg, 0);
        chk("idle_ports", dut_ports(), 0);
        advance();

        // Sparse producers 0, 2, 5.
        v[0] = 1; t[0] = 7;  d[0] = 10;
        v[2] = 1; t[2] = 9;  d[2] = 20;
        v[5] = 1; t[5] = 11; d[5] = 30;
        drive();
        sample();
        chk("sparse_ready", bus.req_ready, 6'b100101);
        e = mk_lit(0, 7, 10) | mk_lit(1, 9, 20) | mk_lit(2, 11, 30);
        lits_pre("sparse_ports", e);
        advance();
        chk("sparse_ptr", rr_ptr_dbg, 0);
        lits_post("sparse_ports", e);

        // Oversubscription: six producers, four ports.
        for (int i = 0; i < N; i++) begin
            v[i] = 1; t[i] = TAG_W'(i + 1); d[i] = 100 + i;
        end
        drive();
        sample();
        chk("over1_ready", bus.req_ready, 6'b001111);
        e = mk_lit(0, 1, 100) | mk_lit(1, 2, 101) | mk_lit(2, 3, 102) | mk_lit(3, 4, 103);
        lits_pre("over1_ports", e);
        advance();
        chk("over1_ptr", rr_ptr_dbg, 4);
        lits_post("over1_ports", e);
        for (int i = 0; i < 4; i++) begin
            v[i] = 1; t[i] = TAG_W'(i + 7); d[i] = 200 + i;
        end
        drive();
        sample();
        chk("over2_ready", bus.req_ready, 6'b110011);
        e = mk_lit(0, 5, 104) | mk_lit(1, 6, 105) | mk_lit(2, 7, 200) | mk_lit(3, 8, 201);
        lits_pre("over2_ports", e);
        advance();
        chk("over2_ptr", rr_ptr_dbg, 2);
        lits_post("over2_ports", e);
        sample();
        advance();

        // x0 bypass: consumes no port and does not move the pointer.
        v[1] = 1; t[1] = 0;  d[1] = 55;
        v[2] = 1; t[2] = 12; d[2] = 66;
        drive();
        sample();
        chk("x0_ready", bus.req_ready, 6'b000110);
        e = mk_lit(0, 12, 66);
        lits_pre("x0_ports", e);
        advance();
        chk("x0_ptr", rr_ptr_dbg, 3);
        lits_post("x0_ports", e);

        // Single broadcast, then an idle cycle must be silent.
        v[3] = 1; t[3] = 40; d[3] = 456;
        drive();
        sample();
        e = mk_lit(0, 40, 456);
        lits_pre("single_ports", e);
        advance();
        lits_post("single_ports", e);
        sample();
        lits_pre("single_idle", '0);
        advance();
        lits_post("single_idle", '0);

        // Reset mid-stream with requests pending.
        for (int i = 0; i < N; i++) begin
            v[i] = 1; t[i] = TAG_W'(i + 20); d[i] = $urandom;
        end
        drive();
        sample();
        advance();
        for (int i = 0; i < N; i++) begin
            if (!v[i]) begin
                v[i] = 1; t[i] = TAG_W'(i + 30); d[i] = $urandom;
            end
        end
        drive();
        sample();
        #2;
        reset = 1'b0;
        m_ptr = 0;
        #1;
        chk("midrst_ready", bus.req_ready, 0);
        chk("midrst_ports", dut_ports(), 0);
        chk("midrst_ptr", rr_ptr_dbg, 0);
        advance();
        sample();
        advance();
        reset = 1'b1;
        sample();
        chk("release_ready", bus.req_ready, 6'b001111);
        e = mk_lit(0, t[0], d[0]) | mk_lit(1, t[1], d[1]) | mk_lit(2, t[2], d[2]) | mk_lit(3, t[3], d[3]);
        lits_pre("release_ports", e);
        advance();
        lits_post("release_ports", e);

        // Randomized producers with unique tags; producer 0 occasionally carries x0.
        clear_all();
        drive();
        sample();
        advance();
        fair_en = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom_range(0, 99) < 55)) begin
                    r = 3'($urandom_range(0, 7));
                    v[i] = 1'b1;
                    t[i] = {r, 3'(i)};
                    d[i] = $urandom;
                    wait_cyc[i] = 0;
                end
            end
            drive();
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
